sync_wedge_tx: RTL and testbench
================================

// Module: sync_wedge_tx
// PURPOSE
// - Transmit side of an edge-signalling wire that is synchronised and edge-detected in another clock domain.
// - Turns handshaked level/pulse requests into a registered, glitch-free serial_o.
// - Every level is held >= MIN_HOLD clk_i cycles, so a multi-stage synchroniser on a slower receiving clock sees each edge.
// - Sits in the sending domain; serial_o routes straight to the receiving domain's synchroniser input.
// PARAMETERS
// - MIN_HOLD  default 4  min clk_i cycles serial_o stays stable after any transition; legal range >= 1
// - CNT_W     localparam $clog2(MIN_HOLD+1)  hold-counter width; not overridable
// PORTS
// - clk_i        in   1  single clock
// - rst_ni       in   1  asynchronous, active-low reset
// - en_i         in   1  clock enable; when low, all state is frozen
// - req_valid_i  in   1  request valid
// - req_ready_o  out  1  request ready; transfer when valid & ready at posedge clk_i
// - req_op_i     in   2  sync_wedge_pkg::op_e: OP_NOP=0, OP_SET=1, OP_CLR=2, OP_PULSE=3
// - serial_o     out  1  registered serial level toward the other domain
// - busy_o       out  1  FSM not in IDLE (hold or pulse in progress)
// BEHAVIOUR
// - Reset (async, immediate, including mid-operation):
//   - serial_o=0, state=IDLE, counter=0, busy_o=0, req_ready_o=1 (if en_i=1).
//   - An interrupted pulse or hold is dropped.
// - req_ready_o = en_i & (state==IDLE); combinational, never depends on req_valid_i.
// - FSM states: IDLE, HOLD, PULSE_HI.
// - Accept at edge N, OP_SET with serial_o=0 (CLR with serial_o=1 is symmetric):
//   - serial_o toggles at edge N; counter loads MIN_HOLD-1.
//   - Next state is HOLD, or IDLE if MIN_HOLD==1.
// - OP_SET with serial_o=1, OP_CLR with serial_o=0, or OP_NOP: accepted, no transition, stays IDLE, ready remains 1.
// - OP_PULSE accepted at edge N:
//   - serial_o rises at edge N (state PULSE_HI) and falls at edge N+MIN_HOLD (state HOLD).
//   - Back to IDLE so a new request can be accepted at edge N+2*MIN_HOLD.
//   - If serial_o is already 1, OP_PULSE behaves as OP_CLR: one falling edge, then hold.
// - HOLD: counter decrements each enabled cycle; at 0 -> IDLE.
//   - Next transition is possible no earlier than edge N+MIN_HOLD after the previous one.
// - PULSE_HI: counter at 0 -> drive serial_o=0, reload MIN_HOLD-1, -> HOLD (or IDLE if MIN_HOLD==1).
// - en_i=0: no accept, counter frozen, serial_o held, state held. Hold time is counted in enabled cycles only.
// - req_valid_i while ready=0: ignored. Requester must hold valid/op stable until accepted; no request buffering.
// - Counter never wraps: it saturates at 0 and is only loaded on a transition.
// - busy_o = (state!=IDLE), registered-state derived; reset 0.
// STRUCTURE
// - sync_wedge_pkg: op_e enum (2 bits) and state_e enum (IDLE/HOLD/PULSE_HI).
// - One natural sub-module, sync_wedge_hold_cnt:
//   - load/decrement/enable down-counter, CNT_W wide; outputs zero flag.
// - Top: FSM plus serial_o flop, all flops on clk_i/rst_ni with en_i as enable.
// TESTING
// - MIN_HOLD=4, OP_SET accepted at edge 0:
//   - serial_o=1 from edge 0; ready=0 in cycles 1..3.
//   - ready=1 in cycle 4; OP_CLR drops serial_o at edge 4.
// - OP_PULSE at edge 10: serial_o high for exactly 4 cycles (edges 10..14), then low; busy_o=1 until cycle 18, ready=1 at 18.
// - OP_SET while serial_o=1: accepted same cycle, serial_o unchanged, busy_o stays 0, back-to-back accept next cycle.
// - en_i=0 for 3 cycles during HOLD: serial_o stable, ready=0; hold extends by 3 cycles.
// - rst_ni low mid-PULSE_HI: serial_o=0 asynchronously; after release ready=1, busy_o=0, fresh OP_PULSE works.
// - MIN_HOLD=1: SET, CLR, SET on consecutive edges toggle serial_o every cycle; ready never drops.

Source files
------------

// File: rtl/sync_wedge_pkg.sv
// Shared types for the sync_wedge transmitter: request opcodes and FSM states.
package sync_wedge_pkg;

   // Request opcodes carried on req_op_i.
   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_SET   = 2'd1,
      OP_CLR   = 2'd2,
      OP_PULSE = 2'd3
   } op_e;

   // Transmitter FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      PULSE_HI = 2'd2
   } state_e;

   // Width needed to hold a count of 0..min_hold.
   function automatic int hold_cnt_width(input int min_hold);
      return $clog2(min_hold + 1);
   endfunction

endpackage

// File: rtl/sync_wedge_hold_cnt.sv
// Load/decrement down-counter used to time how long serial_o stays put.
// It saturates at zero and only changes value on a load or a decrement.
module sync_wedge_hold_cnt
   import sync_wedge_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic             one
);

   logic [CNT_W-1:0] count;

   // Load has priority over decrement; decrement stops at zero so it never wraps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (en) begin
         if (load) begin
            count <= load_val;
         end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
         end
      end
   end

   assign zero = (count == '0);
   assign one  = (count == CNT_W'(1));

endmodule

// File: rtl/sync_wedge_tx.sv
// Transmit side of an edge-signalling wire. Requests (set/clear/pulse) are
// turned into a registered serial level whose every value is held for at
// least MIN_HOLD enabled clocks, so a slow receiving synchroniser sees
// every edge.
module sync_wedge_tx
   import sync_wedge_pkg::*;
#(
   parameter int MIN_HOLD = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [1:0] req_op_i,
   output logic       serial_o,
   output logic       busy_o
);

   localparam int CNT_W = hold_cnt_width(MIN_HOLD);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_HOLD - 1);
   // With a one-cycle hold there is nothing left to wait for after an edge.
   localparam state_e POST_EDGE = (MIN_HOLD == 1) ? IDLE : HOLD;

   state_e state;
   state_e state_next;
   logic   serial;
   logic   serial_next;
   logic   ready;
   logic   accept;
   op_e    op;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_zero;
   logic   cnt_one;

   assign ready       = en_i & (state == IDLE);
   assign accept      = req_valid_i & ready;
   assign op          = op_e'(req_op_i);
   assign req_ready_o = ready;
   assign serial_o    = serial;
   assign busy_o      = (state != IDLE);

   sync_wedge_hold_cnt #(
      .CNT_W (CNT_W)
   ) u_hold_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en       (en_i),
      .load     (cnt_load),
      .load_val (RELOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .one      (cnt_one)
   );

   // Next-state, next serial level and counter control.
   always_comb begin
      state_next  = state;
      serial_next = serial;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_SET: begin
                     if (!serial) begin
                        serial_next = 1'b1;
                        cnt_load    = 1'b1;
                        state_next  = POST_EDGE;
                     end
                  end
                  OP_CLR: begin
                     if (serial) begin
                        serial_next = 1'b0;
                        cnt_load    = 1'b1;
                        state_next  = POST_EDGE;
                     end
                  end
                  OP_PULSE: begin
                     // A pulse on an already-high line degenerates to a clear.
                     serial_next = ~serial;
                     cnt_load    = 1'b1;
                     state_next  = serial ? POST_EDGE : PULSE_HI;
                  end
                  default: begin
                  end
               endcase
            end
         end
         HOLD: begin
            // Leave as the count reaches zero so the next edge can land
            // exactly MIN_HOLD cycles after the previous one.
            cnt_dec = 1'b1;
            if (cnt_zero || cnt_one) begin
               state_next = IDLE;
            end
         end
         PULSE_HI: begin
            // High phase lasts until the count has run out completely.
            if (cnt_zero) begin
               serial_next = 1'b0;
               cnt_load    = 1'b1;
               state_next  = POST_EDGE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and serial level registers; frozen whenever en_i is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         serial <= 1'b0;
      end else if (en_i) begin
         state  <= state_next;
         serial <= serial_next;
      end
   end

endmodule

// File: tb/tb_sync_wedge_tx.sv
// Bench for sync_wedge_tx: two instances (MIN_HOLD=4 and MIN_HOLD=1) share
// stimulus; a timeline model based on enabled-edge indices predicts outputs.
module tb_sync_wedge_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       valid;
   logic [1:0] op;
   logic       rdy0, ser0, bsy0;
   logic       rdy1, ser1, bsy1;

   int nvec = 0;
   int nbad = 0;

   // Reference model, one slot per instance: level on the wire, index of the
   // next enabled edge, edge index from which a request may be accepted, and
   // the edge index of a pending pulse fall (-1 when none).
   int mh[2]      = '{4, 1};
   int lvl[2];
   int tcnt[2];
   int free_at[2];
   int fall_at[2];

   always #5 clk = ~clk;

   sync_wedge_tx #(.MIN_HOLD(4)) dut4 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .req_valid_i (valid),
      .req_ready_o (rdy0),
      .req_op_i    (op),
      .serial_o    (ser0),
      .busy_o      (bsy0)
   );

   sync_wedge_tx #(.MIN_HOLD(1)) dut1 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .req_valid_i (valid),
      .req_ready_o (rdy1),
      .req_op_i    (op),
      .serial_o    (ser1),
      .busy_o      (bsy1)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         lvl[i]     = 0;
         tcnt[i]    = 0;
         free_at[i] = 0;
         fall_at[i] = -1;
      end
   endtask

   function automatic logic exp_ready(input int i);
      return en && (tcnt[i] >= free_at[i]);
   endfunction

   function automatic logic exp_busy(input int i);
      return tcnt[i] < free_at[i];
   endfunction

   // Apply one clock edge to the model using the currently driven inputs.
   task automatic model_edge(input int i);
      int k;
      if (en) begin
         k = tcnt[i];
         if (fall_at[i] == k) begin
            lvl[i]     = 0;
            fall_at[i] = -1;
         end
         if (valid && (k >= free_at[i])) begin
            if ((op == 2'd1 && lvl[i] == 0) || (op == 2'd2 && lvl[i] == 1) ||
                (op == 2'd3 && lvl[i] == 1)) begin
               lvl[i]     = 1 - lvl[i];
               free_at[i] = k + mh[i];
            end else if (op == 2'd3) begin
               lvl[i]     = 1;
               fall_at[i] = k + mh[i];
               free_at[i] = k + 2 * mh[i];
            end
         end
         tcnt[i] = k + 1;
      end
   endtask

   task automatic check_all();
      chk("ready_mh4",  rdy0, exp_ready(0));
      chk("busy_mh4",   bsy0, exp_busy(0));
      chk("serial_mh4", ser0, logic'(lvl[0] != 0));
      chk("ready_mh1",  rdy1, exp_ready(1));
      chk("busy_mh1",   bsy1, exp_busy(1));
      chk("serial_mh1", ser1, logic'(lvl[1] != 0));
   endtask

   task automatic step(input logic v, input logic [1:0] o, input logic e);
      @(negedge clk);
      valid = v;
      op    = o;
      en    = e;
      #1;
      check_all();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
   endtask

   // Reset asserted between edges: outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_serial_mh4", ser0, 1'b0);
      chk("rst_busy_mh4",   bsy0, 1'b0);
      chk("rst_serial_mh1", ser1, 1'b0);
      chk("rst_busy_mh1",   bsy1, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      valid = 1'b0;
      op    = 2'd0;
      model_reset();
      #12;
      rst_n = 1'b1;

      // SET at edge 0, CLR held while busy and accepted at edge 4.
      step(1'b1, 2'd1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1);
      // Pulse at edge 10, idle through edge 17, new request at 18.
      step(1'b1, 2'd3, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 2'd0, 1'b1);
      step(1'b1, 2'd1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1);
      // SET on a high line: no-op accepts back to back.
      step(1'b1, 2'd1, 1'b1);
      step(1'b1, 2'd1, 1'b1);
      step(1'b1, 2'd0, 1'b1);
      // CLR then a 3-cycle enable gap in the middle of the hold.
      step(1'b1, 2'd2, 1'b1);
      step(1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);
      // Reset in the middle of a pulse, then a fresh pulse.
      step(1'b1, 2'd3, 1'b1);
      step(1'b0, 2'd0, 1'b1);
      step(1'b0, 2'd0, 1'b1);
      do_reset();
      step(1'b1, 2'd3, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b0, 2'd0, 1'b1);
      // MIN_HOLD=1 toggling on consecutive edges.
      step(1'b1, 2'd1, 1'b1);
      step(1'b1, 2'd2, 1'b1);
      step(1'b1, 2'd1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b1);

      // Randomised traffic with enable gaps and occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         step(logic'($urandom_range(0, 2) != 0),
              2'($urandom_range(0, 3)),
              logic'($urandom_range(0, 7) != 0));
      end

      @(negedge clk);
      valid = 1'b0;
      #1;
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
